// File: rtl/rob_pkg.sv
// Shared types for the reorder-buffer control stage: entry layout, instruction
// type encodings and the occupancy test used for CDB tag filtering.
package rob_pkg;

    localparam int DEPTH = 32;
    localparam int TAG_W = $clog2(DEPTH);
    localparam int CNT_W = TAG_W + 1;

    typedef enum logic [1:0] {
        TYPE_ALU    = 2'b00,
        TYPE_LOAD   = 2'b01,
        TYPE_STORE  = 2'b10,
        TYPE_BRANCH = 2'b11
    } inst_type_e;

    // Packed field order fixes the 73-bit temp-file layout:
    // rd[72:68] pc[67:36] type[35:34] data[33:2] spec_valid[1] valid[0].
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] pc;
        inst_type_e  itype;
        logic [31:0] data;
        logic        spec_valid;
        logic        valid;
    } rob_entry_t;

    // An entry is live when its distance from head (mod DEPTH) is below the occupancy.
    function automatic logic tag_live(input logic [TAG_W-1:0] tag,
                                      input logic [TAG_W-1:0] head,
                                      input logic [CNT_W-1:0] count);
        logic [TAG_W-1:0] offset;
        offset = tag - head;
        return {1'b0, offset} < count;
    endfunction

endpackage

// File: rtl/rob_ctrl_if.sv
// Dispatch, CDB, temp-file and commit signals of the reorder-buffer control stage.
interface rob_ctrl_if;
    import rob_pkg::*;

    logic             disp_valid;
    logic             disp_ready;
    logic [4:0]       disp_rd;
    logic [31:0]      disp_pc;
    logic [1:0]       disp_type;
    logic [TAG_W-1:0] disp_tag;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             flush;

    rob_entry_t       rf_data_in;
    logic [TAG_W-1:0] rf_waddr;
    logic             rf_new_entry;
    logic             rf_update_entry;
    logic [TAG_W-1:0] rf_rd_addr1;
    rob_entry_t       rf_data_out1;

    logic             commit_valid;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_data;
    logic [31:0]      commit_pc;
    logic [1:0]       commit_type;
    logic [TAG_W-1:0] commit_tag;
    logic             commit_wr_en;
    logic [CNT_W-1:0] count;

    modport master (
        output disp_valid, disp_rd, disp_pc, disp_type, cdb_valid, cdb_tag, cdb_data,
               flush, rf_data_out1,
        input  disp_ready, disp_tag, rf_data_in, rf_waddr, rf_new_entry, rf_update_entry,
               rf_rd_addr1, commit_valid, commit_rd, commit_data, commit_pc, commit_type,
               commit_tag, commit_wr_en, count
    );

    modport slave (
        input  disp_valid, disp_rd, disp_pc, disp_type, cdb_valid, cdb_tag, cdb_data,
               flush, rf_data_out1,
        output disp_ready, disp_tag, rf_data_in, rf_waddr, rf_new_entry, rf_update_entry,
               rf_rd_addr1, commit_valid, commit_rd, commit_data, commit_pc, commit_type,
               commit_tag, commit_wr_en, count
    );

endinterface

// File: rtl/rob_ctrl.sv
// Reorder-buffer control: in-order allocation, CDB speculative updates and in-order
// retirement, arbitrating the single temp-file write port (flush > CDB > dispatch).
module rob_ctrl
    import rob_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    rob_ctrl_if.slave bus
);

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             commit_valid_q;
    logic             commit_wr_en_q;
    logic [4:0]       commit_rd_q;
    logic [31:0]      commit_data_q;
    logic [31:0]      commit_pc_q;
    inst_type_e       commit_type_q;
    logic [TAG_W-1:0] commit_tag_q;

    logic       full;
    logic       cdb_hit;
    logic       accept;
    logic       commit;
    rob_entry_t head_entry;
    rob_entry_t wr_entry;

    assign head_entry = bus.rf_data_out1;
    assign full       = (count_q == CNT_W'(DEPTH));
    assign cdb_hit    = bus.cdb_valid && tag_live(bus.cdb_tag, head_q, count_q);

    // A live CDB result owns the write port, so dispatch stalls for that cycle.
    assign bus.disp_ready = !reset && !bus.flush && !full && !cdb_hit;
    assign accept         = bus.disp_valid && bus.disp_ready;
    assign commit         = !reset && !bus.flush && (count_q != '0)
                            && head_entry.valid && head_entry.spec_valid;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        bus.rf_new_entry    = 1'b0;
        bus.rf_update_entry = 1'b0;
        bus.rf_waddr        = '0;
        wr_entry            = '0;
        if (cdb_hit && !reset && !bus.flush) begin
            bus.rf_update_entry = 1'b1;
            bus.rf_waddr        = bus.cdb_tag;
            wr_entry.data       = bus.cdb_data;
            wr_entry.spec_valid = 1'b1;
        end else if (accept) begin
            bus.rf_new_entry = 1'b1;
            bus.rf_waddr     = tail_q;
            wr_entry.rd      = bus.disp_rd;
            wr_entry.pc      = bus.disp_pc;
            wr_entry.itype   = inst_type_e'(bus.disp_type);
            wr_entry.valid   = 1'b1;
        end
    end

    assign bus.rf_data_in = wr_entry;

    always_comb begin
        head_d  = head_q + TAG_W'(commit);
        tail_d  = tail_q + TAG_W'(accept);
        count_d = count_q;
        if (accept && !commit) begin
            count_d = count_q + CNT_W'(1);
        end else if (commit && !accept) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset || bus.flush) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_wr_en_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_data_q  <= '0;
            commit_pc_q    <= '0;
            commit_type_q  <= TYPE_ALU;
            commit_tag_q   <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit;
            commit_wr_en_q <= commit && (head_entry.itype == TYPE_ALU
                                         || head_entry.itype == TYPE_LOAD);
            if (commit) begin
                commit_rd_q   <= head_entry.rd;
                commit_data_q <= head_entry.data;
                commit_pc_q   <= head_entry.pc;
                commit_type_q <= head_entry.itype;
                commit_tag_q  <= head_q;
            end
        end
    end

    assign bus.disp_tag     = tail_q;
    assign bus.rf_rd_addr1  = head_q;
    assign bus.count        = count_q;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_wr_en = commit_wr_en_q;
    assign bus.commit_rd    = commit_rd_q;
    assign bus.commit_data  = commit_data_q;
    assign bus.commit_pc    = commit_pc_q;
    assign bus.commit_type  = commit_type_q;
    assign bus.commit_tag   = commit_tag_q;

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl with a temp-file model and a commit scoreboard whose
// expectations are queued by the stimulus and checked by an independent monitor.
module tb_rob_ctrl;
    import rob_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    rob_ctrl_if bus ();
    rob_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Temp register file model: new entries overwrite, updates merge data and spec_valid.
    rob_entry_t tf [DEPTH];
    always @(posedge clock) begin
        if (reset) begin
            foreach (tf[i]) tf[i] <= '0;
        end else if (bus.rf_new_entry) begin
            tf[bus.rf_waddr] <= bus.rf_data_in;
        end else if (bus.rf_update_entry) begin
            tf[bus.rf_waddr].data       <= bus.rf_data_in.data;
            tf[bus.rf_waddr].spec_valid <= 1'b1;
        end
    end
    assign bus.rf_data_out1 = tf[bus.rf_rd_addr1];

    typedef struct {
        int          cyc;
        logic [4:0]  tag;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] data;
        logic [1:0]  ty;
        logic        wr_en;
    } exp_commit_t;
    exp_commit_t exp_q[$];

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called in the cycle whose closing edge must retire the given entry.
    task automatic expect_commit(input logic [4:0] tag, input logic [4:0] rd,
                                 input logic [31:0] pc, input logic [1:0] ty,
                                 input logic [31:0] data);
        exp_commit_t e;
        e.cyc   = cyc + 1;
        e.tag   = tag;
        e.rd    = rd;
        e.pc    = pc;
        e.data  = data;
        e.ty    = ty;
        e.wr_en = (ty == 2'b00) || (ty == 2'b01);
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        exp_commit_t e;
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            check("commit_missing_cycle", 73'(cyc), 73'(exp_q[0].cyc));
            void'(exp_q.pop_front());
        end
        if (bus.commit_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("commit_unexpected", 73'(bus.commit_valid), 73'(0));
            end else begin
                e = exp_q.pop_front();
                check("commit_cycle", 73'(cyc), 73'(e.cyc));
                check("commit_tag", 73'(bus.commit_tag), 73'(e.tag));
                check("commit_rd", 73'(bus.commit_rd), 73'(e.rd));
                check("commit_pc", 73'(bus.commit_pc), 73'(e.pc));
                check("commit_data", 73'(bus.commit_data), 73'(e.data));
                check("commit_type", 73'(bus.commit_type), 73'(e.ty));
                check("commit_wr_en", 73'(bus.commit_wr_en), 73'(e.wr_en));
            end
        end
    end

    task automatic clear_inputs();
        bus.disp_valid = 1'b0;
        bus.disp_rd    = '0;
        bus.disp_pc    = '0;
        bus.disp_type  = '0;
        bus.cdb_valid  = 1'b0;
        bus.cdb_tag    = '0;
        bus.cdb_data   = '0;
        bus.flush      = 1'b0;
    endtask

    task automatic dispatch(input logic [4:0] rd, input logic [31:0] pc,
                            input logic [1:0] ty, input logic [4:0] exp_tag);
        logic [72:0] exp_word;
        exp_word       = {rd, pc, ty, 32'h0, 1'b0, 1'b1};
        bus.disp_valid = 1'b1;
        bus.disp_rd    = rd;
        bus.disp_pc    = pc;
        bus.disp_type  = ty;
        #1;
        check("disp_ready", 73'(bus.disp_ready), 73'(1));
        check("disp_tag", 73'(bus.disp_tag), 73'(exp_tag));
        check("disp_new_entry", 73'(bus.rf_new_entry), 73'(1));
        check("disp_update_entry", 73'(bus.rf_update_entry), 73'(0));
        check("disp_waddr", 73'(bus.rf_waddr), 73'(exp_tag));
        check("disp_data_in", bus.rf_data_in, exp_word);
        @(negedge clock);
        bus.disp_valid = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] data, input logic live);
        logic [72:0] exp_word;
        exp_word      = {5'h0, 32'h0, 2'b00, data, 1'b1, 1'b0};
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
        #1;
        check("cdb_update_entry", 73'(bus.rf_update_entry), 73'(live));
        check("cdb_new_entry", 73'(bus.rf_new_entry), 73'(0));
        if (live) begin
            check("cdb_waddr", 73'(bus.rf_waddr), 73'(tag));
            check("cdb_data_in", bus.rf_data_in, exp_word);
        end
        @(negedge clock);
        bus.cdb_valid = 1'b0;
    endtask

    task automatic check_state(input string name, input logic [5:0] cnt,
                               input logic [4:0] head, input logic [4:0] tail);
        check({name, "_count"}, 73'(bus.count), 73'(cnt));
        check({name, "_head"}, 73'(bus.rf_rd_addr1), 73'(head));
        check({name, "_tail"}, 73'(bus.disp_tag), 73'(tail));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        reset          = 1'b1;
        bus.disp_valid = 1'b1;
        bus.cdb_valid  = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check("reset_new_entry", 73'(bus.rf_new_entry), 73'(0));
        check("reset_update_entry", 73'(bus.rf_update_entry), 73'(0));
        check("reset_commit_valid", 73'(bus.commit_valid), 73'(0));
        reset = 1'b0;
        clear_inputs();
        #1;
        check_state("reset", 6'd0, 5'd0, 5'd0);
        check("reset_disp_ready", 73'(bus.disp_ready), 73'(1));
        @(negedge clock);

        // Three ALU dispatches, then out-of-order completion with in-order retirement.
        dispatch(5'd1, 32'h100, 2'b00, 5'd0);
        dispatch(5'd2, 32'h104, 2'b00, 5'd1);
        dispatch(5'd3, 32'h108, 2'b00, 5'd2);
        check_state("after_3_disp", 6'd3, 5'd0, 5'd3);
        cdb(5'd1, 32'hAA, 1'b1);
        cdb(5'd0, 32'h55, 1'b1);
        expect_commit(5'd0, 5'd1, 32'h100, 2'b00, 32'h55);
        @(negedge clock);
        expect_commit(5'd1, 5'd2, 32'h104, 2'b00, 32'hAA);
        @(negedge clock);
        check_state("tag2_pending", 6'd1, 5'd2, 5'd3);

        // A result for a tag that is not live is dropped and does not stall dispatch.
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 5'd9;
        #1;
        check("stale_cdb_disp_ready", 73'(bus.disp_ready), 73'(1));
        clear_inputs();
        cdb(5'd9, 32'h99, 1'b0);

        // Store at head retires without a register-file write.
        dispatch(5'd7, 32'h200, 2'b10, 5'd3);
        cdb(5'd2, 32'h22, 1'b1);
        expect_commit(5'd2, 5'd3, 32'h108, 2'b00, 32'h22);
        cdb(5'd3, 32'h33, 1'b1);
        expect_commit(5'd3, 5'd7, 32'h200, 2'b10, 32'h33);
        @(negedge clock);
        check_state("after_store", 6'd0, 5'd4, 5'd4);

        // CDB and dispatch collide: the update wins, dispatch retries with the same tag.
        dispatch(5'd4, 32'h300, 2'b01, 5'd4);
        bus.disp_valid = 1'b1;
        bus.disp_rd    = 5'd5;
        bus.disp_pc    = 32'h304;
        bus.disp_type  = 2'b11;
        bus.cdb_valid  = 1'b1;
        bus.cdb_tag    = 5'd4;
        bus.cdb_data   = 32'h44;
        #1;
        check("collide_disp_ready", 73'(bus.disp_ready), 73'(0));
        check("collide_disp_tag", 73'(bus.disp_tag), 73'(5));
        check("collide_new_entry", 73'(bus.rf_new_entry), 73'(0));
        check("collide_update_entry", 73'(bus.rf_update_entry), 73'(1));
        check("collide_waddr", 73'(bus.rf_waddr), 73'(4));
        @(negedge clock);
        bus.cdb_valid = 1'b0;
        expect_commit(5'd4, 5'd4, 32'h300, 2'b01, 32'h44);
        dispatch(5'd5, 32'h304, 2'b11, 5'd5);
        cdb(5'd5, 32'h5555, 1'b1);
        expect_commit(5'd5, 5'd5, 32'h304, 2'b11, 32'h5555);
        @(negedge clock);
        check_state("after_branch", 6'd0, 5'd6, 5'd6);

        // Flush with five live entries, a completed head and a concurrent CDB/dispatch.
        for (int i = 0; i < 5; i++) begin
            dispatch(5'(10 + i), 32'h400 + 32'(4 * i), 2'b00, 5'(6 + i));
        end
        cdb(5'd6, 32'h66, 1'b1);
        bus.flush      = 1'b1;
        bus.cdb_valid  = 1'b1;
        bus.cdb_tag    = 5'd8;
        bus.cdb_data   = 32'h88;
        bus.disp_valid = 1'b1;
        bus.disp_rd    = 5'd20;
        #1;
        check("flush_new_entry", 73'(bus.rf_new_entry), 73'(0));
        check("flush_update_entry", 73'(bus.rf_update_entry), 73'(0));
        check("flush_disp_ready", 73'(bus.disp_ready), 73'(0));
        @(negedge clock);
        clear_inputs();
        check_state("after_flush", 6'd0, 5'd0, 5'd0);
        check("flush_commit_rd", 73'(bus.commit_rd), 73'(0));
        check("flush_commit_tag", 73'(bus.commit_tag), 73'(0));
        // Head slot 0 still holds a stale completed entry; an empty buffer must ignore it.
        repeat (3) @(negedge clock);
        check_state("empty_idle", 6'd0, 5'd0, 5'd0);

        // Fill all 32 entries, then free one slot and wrap the tail back to 0.
        for (int i = 0; i < DEPTH; i++) begin
            dispatch(5'(i), 32'h1000 + 32'(4 * i), 2'b00, 5'(i));
        end
        bus.disp_valid = 1'b1;
        bus.disp_rd    = 5'd9;
        bus.disp_pc    = 32'h2000;
        bus.disp_type  = 2'b11;
        #1;
        check_state("full", 6'd32, 5'd0, 5'd0);
        check("full_disp_ready", 73'(bus.disp_ready), 73'(0));
        check("full_new_entry", 73'(bus.rf_new_entry), 73'(0));
        @(negedge clock);
        bus.disp_valid = 1'b0;
        cdb(5'd0, 32'hF0, 1'b1);
        expect_commit(5'd0, 5'd0, 32'h1000, 2'b00, 32'hF0);
        bus.disp_valid = 1'b1;
        #1;
        check("full_commit_disp_ready", 73'(bus.disp_ready), 73'(0));
        check("full_commit_new_entry", 73'(bus.rf_new_entry), 73'(0));
        @(negedge clock);
        check("after_full_commit_count", 73'(bus.count), 73'(31));
        dispatch(5'd9, 32'h2000, 2'b11, 5'd0);
        check_state("refill", 6'd32, 5'd1, 5'd1);

        repeat (2) @(negedge clock);
        check("scoreboard_drained", 73'(exp_q.size()), 73'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_ctrl.md
# rob_ctrl

Reorder-buffer control stage wrapped around the 32-entry temporary register file (rd_reg/PC/Inst_type/spec_data/spec_valid/valid entries). It allocates entries in program order at dispatch, writes CDB results back as speculative updates, and retires the head entry in order toward the architectural register file and store path. It is the only block that drives the temp file's write port and its read port 1. Read port 2 belongs to the issue stage.

## Interface
- DEPTH, 32, number of entries; must equal temp-file depth; tag width is log2(DEPTH) = 5
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- disp_valid  in  1  dispatch request
- disp_ready  out  1  dispatch accepted this cycle when high with disp_valid
- disp_rd  in  5  destination register
- disp_pc  in  32  instruction PC
- disp_type  in  2  00 ALU, 01 load, 10 store, 11 branch
- disp_tag  out  5  tag assigned to the current request (= tail)
- cdb_valid  in  1  result broadcast
- cdb_tag  in  5  producing entry
- cdb_data  in  32  result value
- flush  in  1  mispredict/exception: discard all entries
- rf_data_in  out  73  to temp file Data_In, layout {rd[72:68], pc[67:36], type[35:34], data[33:2], spec_valid[1], valid[0]}
- rf_waddr  out  5  to temp file Waddr
- rf_new_entry  out  1  to temp file New_entry
- rf_update_entry  out  1  to temp file Update_entry
- rf_rd_addr1  out  5  to temp file Rd_Addr1, always = head
- rf_data_out1  in  73  from temp file Data_out1
- commit_valid  out  1  registered retire pulse
- commit_rd / commit_data / commit_pc / commit_type / commit_tag  out  5/32/32/2/5  retired entry fields
- commit_wr_en  out  1  commit_valid and type is ALU or load
- count  out  6  occupied entries, 0..32

## Operation
- State: head[4:0], tail[4:0], count[5:0]. Reset or flush: all three = 0, and every commit_* output = 0.
- Occupancy: entry t is live iff ((t - head) mod 32) < count.
- Write-port arbitration, one write per cycle:
  - Priority is flush > CDB update > dispatch.
  - disp_ready = !flush && count < 32 && !(cdb_valid && cdb tag live).
- Dispatch accept: rf_new_entry=1, rf_waddr=tail, data_in = {disp_rd, disp_pc, disp_type, 32'h0, 0, 1}. Then tail+1 (wraps 31→0).
- CDB update, tag live: rf_update_entry=1, rf_waddr=cdb_tag, data_in[33:2]=cdb_data, data_in[1]=1, other fields 0.
- CDB update, tag not live: dropped with no write.
- Commit condition: count > 0 && rf_data_out1[0] && rf_data_out1[1] && !flush.
  - On commit: head+1, and the commit_* registers load the head fields next edge.
  - Store and branch commits pulse commit_valid with commit_wr_en=0.
- count update: count + accept − commit. Simultaneous accept and commit leave count unchanged.
- rf_new_entry and rf_update_entry are never both high. Both are 0 during reset and flush.

## Timing
- Dispatch: combinational ready/tag. The entry is written at the accepting edge.
- CDB→readable: 1 cycle after the update edge. A head entry updated at edge N commits at edge N+1, so commit_valid is high during cycle N+2.
- Commit: at most 1 per cycle. Back-to-back ready entries retire on consecutive cycles.
- Full (count=32): disp_ready=0. A commit in the same cycle does not reopen ready until the next cycle.
- Empty: no commit, even if a stale head entry shows valid with spec_valid set.
- Flush mid-stream: takes effect at that edge. A dispatch or CDB update in the same cycle is discarded. Temp-file contents are not cleared; stale entries are invalidated by count=0.

## Structure
- Shared package rob_pkg:
  - type encodings ALU/LOAD/STORE/BRANCH
  - field bit positions of the 73-bit entry
  - TAG_W=5
- No sub-module. The temp file is instantiated by the parent, beside this block.

## Test plan
- Reset, then 3 dispatches (rd 1,2,3; pc 0x100/0x104/0x108; ALU) → tags 0,1,2, count=3, rf_new_entry on 3 consecutive edges.
- CDB tag 1 data 0xAA, then tag 0 data 0x55 → tag 0 commits (rd 1, data 0x55, wr_en=1), then tag 1 on the following cycle; tag 2 stays pending.
- Fill 32 entries → disp_ready=0 at count=32. Complete and commit the head → one more dispatch is accepted to tag 0 (wrap), count=32.
- cdb_valid and disp_valid in the same cycle → only the update is written, disp_ready=0, and the dispatch is accepted next cycle with the same tag.
- Store entry completed at head → commit_valid=1, commit_wr_en=0, commit_type=10.
- flush with 5 live entries plus a concurrent CDB update → count=0, head=tail=0, no temp-file write, no commit; the next dispatch gets tag 0.
